bcd_down_timer: RTL

//  Cascadable multi-decade BCD down-counter/timer. Complement of the up-counting decade

---
 rtl/bcd_down_timer.sv | 86 ++++++++
 1 files changed

// File: rtl/bcd_down_timer.sv
// bcd_down_timer: loadable multi-decade BCD down-counter with expiry pulse.
// Optional BCD_TIMER_AUTO_RELOAD_EN turns expiry into a periodic reload from the last loaded value.
module bcd_down_timer #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   din,
    input  logic                  start,
    input  logic                  stop,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  TC,
    output logic                  busy,
    output logic                  done
);
    localparam int W = 4 * DIGITS;

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state, state_nx;
    logic [W-1:0]   q_nx, din_c, q_dec, rl;
    logic           done_nx, borrow, expire;

    always_comb begin
        for (int i = 0; i < DIGITS; i++)
            din_c[4*i +: 4] = (din[4*i +: 4] > 4'd9) ? 4'd9 : din[4*i +: 4];
    end

    // A digit decrements when every lower digit is zero; all digits settle on one edge.
    always_comb begin
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            q_dec[4*i +: 4] = borrow ? ((Q[4*i +: 4] == 4'd0) ? 4'd9 : Q[4*i +: 4] - 4'd1) : Q[4*i +: 4];
            borrow = borrow & (Q[4*i +: 4] == 4'd0);
        end
    end

`ifdef BCD_TIMER_AUTO_RELOAD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rl <= '0;
        else if (load)
            rl <= din_c;
    end
`else
    assign rl = '0;
`endif

    assign expire = (Q == W'(1));

    always_comb begin
        state_nx = state;
        q_nx     = Q;
        done_nx  = 1'b0;
        if (load) begin
            q_nx     = din_c;
            state_nx = IDLE;
        end else if (stop && state == RUN) begin
            state_nx = IDLE;
        end else if (start && state == IDLE) begin
            state_nx = (Q != '0) ? RUN : IDLE;
        end else if (state == RUN && ce) begin
            // With no reload value, expiry lands on zero and drops back to IDLE.
            q_nx     = expire ? rl : q_dec;
            state_nx = (expire && rl == '0) ? IDLE : RUN;
            done_nx  = expire;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            Q     <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            Q     <= q_nx;
            done  <= done_nx;
        end
    end

    assign busy = (state == RUN);
    assign TC   = (Q == '0);
endmodule
